// File: rtl/mem_pkg.sv
// Shared memory-port definitions: default widths and the request/response
// records used around the single-port memory front-end.
package mem_pkg;

  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      write;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_WIDTH-1:0] rdata;
  } mem_rsp_t;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and the
// memory request front-end (slave).
interface mem_req_ctrl_if
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_rsp_fifo.sv
// Synchronous response FIFO with any depth >= 1; pointers wrap at DEPTH so
// non-power-of-2 depths work. Storage is not reset, only pointers and count.
module mem_rsp_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = MEM_DATA_WIDTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Credit accounting upstream must make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (reset) !(push_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/mem_req_ctrl.sv
// Request front-end for a single-port memory with 1-cycle registered rdata:
// drives the memory pins, captures read data into a credit-limited response FIFO.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  // Credit is registered, so back-to-back reads at full rate need 3 entries.
  parameter int RSP_DEPTH  = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_req_ctrl_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  rd_cnt
);

  localparam int OCC_W = $clog2(RSP_DEPTH + 1);

  logic                 rd_pend_q, rd_pend_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [OCC_W-1:0]     occ;
  logic [31:0]          inflight;
  logic                 credit_ok;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 pop;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Occupancy plus the read already at the memory; pops this cycle add no credit.
  assign inflight  = 32'(occ) + 32'(rd_pend_q);
  assign credit_ok = inflight < 32'(RSP_DEPTH);

  assign bus.req_ready = bus.req_write | credit_ok;
  assign wr_acc        = bus.req_valid & bus.req_ready & bus.req_write;
  assign rd_acc        = bus.req_valid & bus.req_ready & ~bus.req_write;

  assign mem_addr  = bus.req_addr;
  assign mem_wdata = bus.req_wdata;
  assign mem_wr_en = wr_acc;
  assign mem_rd_en = rd_acc;

  always_comb begin
    rd_pend_d = rd_acc;
    wr_cnt_d  = wr_acc ? sat_inc(wr_cnt_q) : wr_cnt_q;
    rd_cnt_d  = rd_acc ? sat_inc(rd_cnt_q) : rd_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Memory rdata is valid the edge after the read was issued.
  assign pop = bus.rsp_valid & bus.rsp_ready;

  mem_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (rd_pend_q),
    .push_data_i (mem_rdata),
    .pop_i       (pop),
    .valid_o     (bus.rsp_valid),
    .data_o      (bus.rsp_rdata),
    .count_o     (occ)
  );

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: a depth-2 instance (A) for function and
// backpressure, a depth-3 instance (B) for full-rate streaming and reset flush.
module tb_mem_req_ctrl;
  import mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mem_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
  mem_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic          mem_wr_en_a, mem_wr_en_b, mem_rd_en_a, mem_rd_en_b;
  logic [DW-1:0] mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
  logic [CW-1:0] wr_cnt_a, rd_cnt_a, wr_cnt_b, rd_cnt_b;

  mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(2), .CNT_WIDTH(CW)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa),
    .mem_addr(mem_addr_a), .mem_wr_en(mem_wr_en_a), .mem_rd_en(mem_rd_en_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
    .wr_cnt(wr_cnt_a), .rd_cnt(rd_cnt_a)
  );

  mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(3), .CNT_WIDTH(CW)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb),
    .mem_addr(mem_addr_b), .mem_wr_en(mem_wr_en_b), .mem_rd_en(mem_rd_en_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .wr_cnt(wr_cnt_b), .rd_cnt(rd_cnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memories: registered rdata, unwritten locations read as all-ones.
  logic [DW-1:0] mem_a [logic [AW-1:0]];
  logic [DW-1:0] mem_b [logic [AW-1:0]];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_a.delete();
      mem_rdata_a <= '1;
    end else begin
      if (mem_rd_en_a) mem_rdata_a <= mem_a.exists(mem_addr_a) ? mem_a[mem_addr_a] : '1;
      if (mem_wr_en_a) mem_a[mem_addr_a] = mem_wdata_a;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_b.delete();
      mem_rdata_b <= '1;
    end else begin
      if (mem_rd_en_b) mem_rdata_b <= mem_b.exists(mem_addr_b) ? mem_b[mem_addr_b] : '1;
      if (mem_wr_en_b) mem_b[mem_addr_b] = mem_wdata_b;
    end
  end

  typedef struct {
    mem_rsp_t rsp;
    int       due;
    bit       timed;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic rsp_check(input bit sel, input logic [DW-1:0] got);
    exp_t e;
    bit   empty;
    checks++;
    empty = sel ? (exp_b.size() == 0) : (exp_a.size() == 0);
    if (empty) begin
      failures++;
      $display("FAIL rsp%s_unexpected actual=%h required=none", sel ? "B" : "A", got);
    end else begin
      if (sel) e = exp_b.pop_front();
      else     e = exp_a.pop_front();
      if (got !== e.rsp.rdata || (e.timed && cyc != e.due)) begin
        failures++;
        $display("FAIL rsp%s actual=%h@cyc%0d required=%h@cyc%0d",
                 sel ? "B" : "A", got, cyc, e.rsp.rdata, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset && ifa.rsp_valid && ifa.rsp_ready) rsp_check(1'b0, ifa.rsp_rdata);
  end

  always @(negedge clk) begin
    if (!reset && ifb.rsp_valid && ifb.rsp_ready) rsp_check(1'b1, ifb.rsp_rdata);
  end

  // Present one request for one cycle; called at posedge+1, returns at posedge+1.
  // For reads, d is the hand-computed expected read data.
  task automatic issue(input bit sel, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit timed, output bit acc);
    exp_t e;
    if (sel) begin
      ifb.req_valid = 1'b1; ifb.req_write = w; ifb.req_addr = a; ifb.req_wdata = d;
    end else begin
      ifa.req_valid = 1'b1; ifa.req_write = w; ifa.req_addr = a; ifa.req_wdata = d;
    end
    @(negedge clk);
    acc = sel ? ifb.req_ready : ifa.req_ready;
    if (acc && !w) begin
      e.rsp.rdata = d;
      e.due       = cyc + 2;
      e.timed     = timed;
      if (sel) exp_b.push_back(e);
      else     exp_a.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel) ifb.req_valid = 1'b0;
    else     ifa.req_valid = 1'b0;
  endtask

  task automatic issue_wait(input string name, input bit sel, input bit w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) issue(sel, w, a, d, 1'b0, acc);
    chk(name, acc, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    reset = 1'b1;
    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifa.rsp_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
    ifb.rsp_ready = 1'b0;
    idle(2);
    chk("reset_rsp_valid_a", ifa.rsp_valid, 1'b0);
    chk("reset_rsp_valid_b", ifb.rsp_valid, 1'b0);
    chk("reset_wr_cnt_a", wr_cnt_a, 0);
    chk("reset_rd_cnt_a", rd_cnt_a, 0);
    reset = 1'b0;
    #1;
    chk("reset_req_ready_a", ifa.req_ready, 1'b1);
    chk("idle_pins_a", {mem_wr_en_a, mem_rd_en_a}, 2'b00);
    idle(1);

    // Write then read back with the consumer always ready.
    ifa.rsp_ready = 1'b1;
    issue(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, acc);
    chk("t1_wr_acc", acc, 1'b1);
    issue(1'b0, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b1, acc);
    chk("t1_rd_acc", acc, 1'b1);
    idle(3);
    chk("t1_wr_cnt", wr_cnt_a, 1);
    chk("t1_rd_cnt", rd_cnt_a, 1);

    issue(1'b0, 1'b0, 16'h1234, 32'hFFFFFFFF, 1'b1, acc);
    chk("t2_rd_acc", acc, 1'b1);

    // Read-after-write on consecutive cycles.
    issue(1'b0, 1'b1, 16'h0005, 32'hA5A50005, 1'b0, acc);
    chk("t3_wr_acc", acc, 1'b1);
    issue(1'b0, 1'b0, 16'h0005, 32'hA5A50005, 1'b1, acc);
    chk("t3_rd_acc", acc, 1'b1);
    idle(3);

    // Backpressure on the depth-2 instance.
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b1, 16'h0020 + 16'(i), 32'hC0DE0020 + 32'(i), 1'b0, acc);
      chk("t4_prewrite_acc", acc, 1'b1);
    end
    ifa.rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 16'h0020, 32'hC0DE0020, 1'b0, acc);
    chk("t4_rd0_acc", acc, 1'b1);
    issue(1'b0, 1'b0, 16'h0021, 32'hC0DE0021, 1'b0, acc);
    chk("t4_rd1_acc", acc, 1'b1);
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 1'b0, 16'h0022, 32'hC0DE0022, 1'b0, acc);
      chk("t4_rd_stall", acc, 1'b0);
    end
    issue(1'b0, 1'b1, 16'h0030, 32'h0BADF00D, 1'b0, acc);
    chk("t4_wr_while_full", acc, 1'b1);
    ifa.rsp_ready = 1'b1;
    issue(1'b0, 1'b0, 16'h0022, 32'hC0DE0022, 1'b0, acc);
    chk("t4_pop_no_same_cycle_credit", acc, 1'b0);
    issue_wait("t4_rd2_acc", 1'b0, 1'b0, 16'h0022, 32'hC0DE0022);
    issue_wait("t4_rd3_acc", 1'b0, 1'b0, 16'h0023, 32'hC0DE0023);
    idle(4);
    chk("t4_drained", exp_a.size(), 0);
    chk("t4_wr_cnt", wr_cnt_a, 7);
    chk("t4_rd_cnt", rd_cnt_a, 7);

    // Full-rate streaming on the depth-3 instance.
    ifb.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, 16'h0100 + 16'(i), 32'h10000000 + 32'(i), 1'b0, acc);
      chk("t5_wr_acc", acc, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 1'b0, 16'h0100 + 16'(i % 4), 32'h10000000 + 32'(i % 4), 1'b1, acc);
      chk("t5_stream_acc", acc, 1'b1);
    end
    idle(4);
    chk("t5_drained", exp_b.size(), 0);
    chk("t5_rd_cnt", rd_cnt_b, 8);

    // Reset with two responses queued and one read in flight.
    ifb.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b0, 16'h0100 + 16'(i), 32'h10000000 + 32'(i), 1'b0, acc);
      chk("t6_rd_acc", acc, 1'b1);
    end
    chk("t6_pre_reset_valid", ifb.rsp_valid, 1'b1);
    chk("t6_pre_reset_rd_block", ifb.req_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_reset_rsp_valid", ifb.rsp_valid, 1'b0);
    chk("t6_reset_wr_cnt_b", wr_cnt_b, 0);
    chk("t6_reset_rd_cnt_b", rd_cnt_b, 0);
    chk("t6_reset_rd_cnt_a", rd_cnt_a, 0);
    exp_a.delete();
    exp_b.delete();
    idle(1);
    reset = 1'b0;
    ifb.rsp_ready = 1'b1;
    idle(6);
    chk("t6_post_rsp_valid", ifb.rsp_valid, 1'b0);
    chk("t6_post_req_ready", ifb.req_ready, 1'b1);
    chk("t6_post_rd_cnt_b", rd_cnt_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
